// File: rtl/sram_be.sv
// Single-port byte-enabled SRAM with optional hardware clear after reset,
// selectable read-during-write behaviour and an optional output pipeline stage.
module sram_be #(
  parameter int N_ENTRIES      = 1024,
  parameter int DATA_WIDTH     = 256,
  parameter bit OUT_REG        = 1'b0,
  parameter bit RDW_MODE       = 1'b0,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [DATA_WIDTH/8-1:0]       we,
  input  logic [$clog2(N_ENTRIES)-1:0]  addr,
  input  logic [DATA_WIDTH-1:0]         data_i,
  output logic [DATA_WIDTH-1:0]         data_o,
  output logic                          valid_o,
  output logic                          busy
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int AW = $clog2(N_ENTRIES);

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_IDLE  = 1'b1;
  localparam logic [0:0] S_RESET = CLEAR_ON_RESET ? S_CLEAR : S_IDLE;

  logic [DATA_WIDTH-1:0] r_mem [N_ENTRIES];
  logic [0:0]            r_state;
  logic [AW-1:0]         r_clr_cnt;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;

  logic                  w_busy;
  logic                  w_access;
  logic [DATA_WIDTH-1:0] w_old_word;
  logic [DATA_WIDTH-1:0] w_merged;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic [AW-1:0]         w_mem_addr;
  logic [DATA_WIDTH-1:0] w_mem_wdata;
  logic [NB-1:0]         w_mem_be;

  assign w_busy     = (r_state == S_CLEAR);
  assign w_access   = en & ~w_busy;
  assign w_old_word = r_mem[addr];
  assign busy       = w_busy;

  // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_merged = w_old_word;
    for (int i = 0; i < NB; i++) begin
      if (we[i]) w_merged[8*i +: 8] = data_i[8*i +: 8];
    end
  end

  assign w_rd_word = RDW_MODE ? w_merged : w_old_word;

  // The clear sequence owns the write port while busy; user requests are dropped.
  always_comb begin
    w_mem_addr  = addr;
    w_mem_wdata = data_i;
    w_mem_be    = w_access ? we : '0;
    if (w_busy) begin
      w_mem_addr  = r_clr_cnt;
      w_mem_wdata = '0;
      w_mem_be    = '1;
    end
    if (rst) w_mem_be = '0;
  end

  // NOTE: the storage array is deliberately not reset; clearing it is the job of the CLEAR sequence, which keeps it mappable to RAM macros.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (w_mem_be[i]) r_mem[w_mem_addr][8*i +: 8] <= w_mem_wdata[8*i +: 8];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_RESET;
      r_clr_cnt <= '0;
    end else if (r_state == S_CLEAR) begin
      r_clr_cnt <= r_clr_cnt + 1'b1;
      if (r_clr_cnt == AW'(N_ENTRIES - 1)) r_state <= S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= w_access;
      if (w_access) r_rd_data <= w_rd_word;
    end
  end

  if (OUT_REG) begin : g_out_reg
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_valid;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_out_valid <= 1'b0;
        r_out_data  <= '0;
      end else begin
        r_out_valid <= r_rd_valid;
        if (r_rd_valid) r_out_data <= r_rd_data;
      end
    end

    assign data_o  = r_out_data;
    assign valid_o = r_out_valid;
  end else begin : g_no_out_reg
    assign data_o  = r_rd_data;
    assign valid_o = r_rd_valid;
  end

endmodule

// File: tb/tb_sram_be.sv
// Bench for sram_be: four cleared instances covering OUT_REG x RDW_MODE share
// one stimulus stream and are compared against an array/history reference model.
module tb_sram_be;

  localparam int N  = 16;
  localparam int DW = 32;
  localparam int NB = DW / 8;
  localparam int AW = 4;

  logic          clk    = 1'b0;
  logic          rst    = 1'b0;
  logic          en     = 1'b0;
  logic [NB-1:0] we     = '0;
  logic [AW-1:0] addr   = '0;
  logic [DW-1:0] data_i = '0;

  logic [DW-1:0] dout [4];
  logic          vout [4];
  logic          bout [4];
  logic [DW-1:0] nc_dout;
  logic          nc_vout;
  logic          nc_busy;

  always #5 clk = ~clk;

  // Instance g: OUT_REG = g/2, RDW_MODE = g%2.
  for (genvar g = 0; g < 4; g++) begin : g_dut
    sram_be #(
      .N_ENTRIES(N), .DATA_WIDTH(DW), .OUT_REG(g >= 2),
      .RDW_MODE((g % 2) == 1), .CLEAR_ON_RESET(1'b1)
    ) u_dut (
      .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .data_i(data_i),
      .data_o(dout[g]), .valid_o(vout[g]), .busy(bout[g])
    );
  end

  sram_be #(
    .N_ENTRIES(N), .DATA_WIDTH(DW), .OUT_REG(1'b0), .RDW_MODE(1'b0), .CLEAR_ON_RESET(1'b0)
  ) u_nc (
    .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .data_i(data_i),
    .data_o(nc_dout), .valid_o(nc_vout), .busy(nc_busy)
  );

  // Reference model: word array, cycles of clear remaining, and a per-edge
  // history of requests with both the pre-write and merged result.
  logic [DW-1:0] mdl [N];
  int            busy_left;
  bit            hv [$];
  logic [DW-1:0] h_old [$];
  logic [DW-1:0] h_new [$];
  logic [DW-1:0] held [4];
  int            errors = 0;
  int            checks = 0;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] w, input logic [DW-1:0] d,
                                          input logic [NB-1:0] be);
    logic [DW-1:0] r;
    r = w;
    for (int i = 0; i < NB; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic compare_all();
    for (int g = 0; g < 4; g++) begin
      int   lat;
      int   idx;
      logic ev;
      logic eb;
      lat = (g >= 2) ? 2 : 1;
      idx = hv.size() - lat;
      ev  = 1'b0;
      if (idx >= 0 && hv[idx]) begin
        ev      = 1'b1;
        held[g] = (g % 2 == 1) ? h_new[idx] : h_old[idx];
      end
      eb = (busy_left > 0);
      checks++;
      if (vout[g] !== ev) begin
        errors++;
        $display("FAIL valid_o dut%0d t=%0t: got %b want %b", g, $time, vout[g], ev);
      end
      checks++;
      if (dout[g] !== held[g]) begin
        errors++;
        $display("FAIL data_o dut%0d t=%0t: got %h want %h", g, $time, dout[g], held[g]);
      end
      checks++;
      if (bout[g] !== eb) begin
        errors++;
        $display("FAIL busy dut%0d t=%0t: got %b want %b", g, $time, bout[g], eb);
      end
    end
    checks++;
    if (nc_busy !== 1'b0) begin
      errors++;
      $display("FAIL busy no-clear t=%0t: got %b want 0", $time, nc_busy);
    end
  endtask

  // One clock: drive request, record expectations, advance, compare.
  task automatic step(input logic e, input logic [NB-1:0] w, input logic [AW-1:0] a,
                      input logic [DW-1:0] d);
    bit            acc;
    logic [DW-1:0] ow;
    logic [DW-1:0] nw;
    en = e; we = w; addr = a; data_i = d;
    acc = e && (busy_left == 0);
    ow  = mdl[a];
    nw  = merge(ow, d, w);
    hv.push_back(acc);
    h_old.push_back(ow);
    h_new.push_back(nw);
    if (acc) mdl[a] = nw;
    @(posedge clk);
    if (busy_left > 0) busy_left--;
    #1;
    en = 1'b0; we = '0;
    compare_all();
  endtask

  task automatic apply_reset();
    en = 1'b0; we = '0;
    #2 rst = 1'b1;
    #1;
    for (int g = 0; g < 4; g++) begin
      checks++;
      if (vout[g] !== 1'b0 || dout[g] !== '0 || bout[g] !== 1'b1) begin
        errors++;
        $display("FAIL reset_state dut%0d: got v=%b d=%h b=%b want v=0 d=0 b=1",
                 g, vout[g], dout[g], bout[g]);
      end
    end
    checks++;
    if (nc_vout !== 1'b0 || nc_dout !== '0 || nc_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state no-clear: got v=%b d=%h b=%b want v=0 d=0 b=0",
               nc_vout, nc_dout, nc_busy);
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    busy_left = N;
    hv.delete(); h_old.delete(); h_new.delete();
    for (int g = 0; g < 4; g++) held[g] = '0;
    for (int i = 0; i < N; i++) mdl[i] = '0;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int i = 0; i < N + 2; i++) step(1'b0, '0, AW'(i), '0);
  endtask

  task automatic test_clear_zero();
    for (int i = 0; i < N; i++) step(1'b1, '0, AW'(i), $urandom);
    step(1'b0, '0, '0, '0);
    step(1'b0, '0, '0, '0);
  endtask

  task automatic test_full_write();
    step(1'b1, 4'hF, 4'd5, 32'hA5A5_A5A5);
    step(1'b1, 4'h0, 4'd5, 32'h0);
    step(1'b0, '0, '0, '0);
    step(1'b0, '0, '0, '0);
  endtask

  task automatic test_byte_enable();
    step(1'b1, 4'hF, 4'd3, 32'h1122_3344);
    step(1'b1, 4'b0101, 4'd3, 32'hAABB_CCDD);
    step(1'b1, 4'h0, 4'd3, 32'h0);
    step(1'b0, '0, '0, '0);
    step(1'b0, '0, '0, '0);
  endtask

  task automatic test_rdw();
    step(1'b1, 4'hF, 4'd3, 32'h1122_3344);
    step(1'b0, '0, '0, '0);
    step(1'b1, 4'hF, 4'd3, 32'hAABB_CCDD);
    step(1'b1, 4'h0, 4'd3, 32'h0);
    step(1'b0, '0, '0, '0);
    step(1'b0, '0, '0, '0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) step(1'b1, '0, AW'(i), $urandom);
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, '0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 3) != 0), NB'($urandom), AW'($urandom), $urandom);
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, '0);
  endtask

  task automatic test_mid_clear_reset();
    apply_reset();
    for (int i = 0; i < 7; i++) step(1'b1, 4'hF, AW'($urandom), $urandom);
    apply_reset();
    for (int i = 0; i < N; i++) step(1'b1, NB'($urandom), AW'($urandom), $urandom);
    for (int i = 0; i < N; i++) step(1'b1, '0, AW'(i), '0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, '0);
  endtask

  task automatic test_mid_read_reset();
    step(1'b1, 4'hF, 4'd7, 32'hDEAD_BEEF);
    step(1'b1, 4'h0, 4'd7, 32'h0);
    apply_reset();
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, '0);
    for (int i = 0; i < N; i++) step(1'b0, '0, '0, '0);
    step(1'b1, 4'h0, 4'd7, 32'h0);
    step(1'b0, '0, '0, '0);
    step(1'b0, '0, '0, '0);
  endtask

  task automatic test_no_clear();
    step(1'b1, 4'hF, 4'd9, 32'h5A5A_1234);
    step(1'b1, 4'h0, 4'd9, 32'h0);
    checks++;
    if (nc_vout !== 1'b1 || nc_dout !== 32'h5A5A_1234) begin
      errors++;
      $display("FAIL no_clear_read: got v=%b d=%h want v=1 d=5a5a1234", nc_vout, nc_dout);
    end
    step(1'b0, '0, '0, '0);
    checks++;
    if (nc_vout !== 1'b0 || nc_dout !== 32'h5A5A_1234) begin
      errors++;
      $display("FAIL no_clear_hold: got v=%b d=%h want v=0 d=5a5a1234", nc_vout, nc_dout);
    end
  endtask

  initial begin
    test_reset();
    test_clear_zero();
    test_full_write();
    test_byte_enable();
    test_rdw();
    test_back_to_back();
    test_random();
    test_mid_clear_reset();
    test_mid_read_reset();
    test_no_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_be.md
SRAM_BE -- requirements
Module: sram_be

Interface
REQ-001 Parameter N_ENTRIES, default 1024, number of words; SHALL be a power of two and at least 2.
REQ-002 Parameter DATA_WIDTH, default 256, word width in bits; SHALL be a multiple of 8.
REQ-003 Parameter OUT_REG, default 0, read latency select: 0 gives 1 cycle, 1 adds an output pipeline register for 2 cycles.
REQ-004 Parameter RDW_MODE, default 0, same-address read-during-write: 0 is read-first (old data), 1 is write-first (merged new data).
REQ-005 Parameter CLEAR_ON_RESET, default 1, 1 means every entry is zeroed by hardware after reset.
REQ-006 clk  input  1  sole clock; all state updates on the rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 en  input  1  access request; ignored while busy=1.
REQ-009 we  input  DATA_WIDTH/8  byte write enables; we[i] covers data bits [8i+7:8i].
REQ-010 addr  input  $clog2(N_ENTRIES)  word address.
REQ-011 data_i  input  DATA_WIDTH  write data.
REQ-012 data_o  output  DATA_WIDTH  registered read data.
REQ-013 valid_o  output  1  one-cycle pulse marking the cycle data_o carries newly read data.
REQ-014 busy  output  1  hardware clear in progress.

Function
REQ-015 The block SHALL have a two-state FSM, CLEAR and IDLE, with a clear counter of width $clog2(N_ENTRIES).
- CLEAR: each cycle, write all-zero to the entry at the counter, then increment the counter.
- After the write to entry N_ENTRIES-1, go to IDLE on the next edge.
- busy=1 exactly while in CLEAR, so CLEAR lasts N_ENTRIES cycles.
REQ-016 With CLEAR_ON_RESET=0, the FSM SHALL sit in IDLE from reset, busy SHALL stay 0, and RAM contents SHALL be undefined.
REQ-017 In CLEAR, en, we, addr and data_i SHALL be ignored: no user write, no valid_o pulse.
REQ-018 Write (IDLE): on an edge with en=1, for each i with we[i]=1, byte i of RAM[addr] takes byte i of data_i; other bytes are unchanged.
REQ-019 Read (IDLE): every edge with en=1 SHALL read RAM[addr], including cycles where some we bit is set.
REQ-020 Latency with OUT_REG=0: the read result SHALL appear on data_o, with valid_o=1, on the edge after en was sampled.
REQ-021 Latency with OUT_REG=1: the result SHALL pass through a stage-1 register, then data_o, with valid_o=1, one edge later; back-to-back reads sustain one result per cycle.
REQ-022 data_o SHALL hold its last value on cycles where no new result arrives; valid_o SHALL be 0 on those cycles.
REQ-023 Same-address read-during-write:
- RDW_MODE=0: the result SHALL be the pre-write word.
- RDW_MODE=1: the result SHALL be the pre-write word with each byte i replaced by data_i byte i where we[i]=1.
REQ-024 Each result SHALL depend only on RAM state and inputs at its own request edge; pipeline stages SHALL not alter it.
REQ-025 The address SHALL have no wrap or out-of-range case; every addr value is a valid entry.

Reset
REQ-026 While rst=1, the block SHALL immediately hold these values regardless of clk:
- data_o=0, valid_o=0, stage-1 register and its valid=0, clear counter=0.
- FSM in CLEAR with busy=1 if CLEAR_ON_RESET=1, else IDLE with busy=0.
REQ-027 Reset SHALL not write RAM; the clear sequence starts on the first edge after rst deasserts.
REQ-028 Reset asserted mid-clear or mid-read SHALL abandon the operation: in-flight results are discarded (no valid_o pulse) and the clear restarts from entry 0.

Verification
REQ-029 N_ENTRIES=16, CLEAR_ON_RESET=1; release rst -> busy=1 for exactly 16 cycles then 0; read of every addr returns 0.
REQ-030 OUT_REG=0; write addr 5 with 0xA5.., we all 1; read addr 5 next cycle -> data_o=0xA5.. and valid_o=1 one edge after the read.
REQ-031 DATA_WIDTH=32, addr 3 holds 0x11223344; write 0xAABBCCDD with we=4'b0101 -> read returns 0x11BB33DD.
REQ-032 DATA_WIDTH=32, addr 3 holds 0x11223344; same-cycle read+write 0xAABBCCDD, we=4'b1111 -> RDW_MODE=0 returns 0x11223344, RDW_MODE=1 returns 0xAABBCCDD; the next read returns 0xAABBCCDD in both modes.
REQ-033 OUT_REG=1; reads of addr 0,1,2 on consecutive cycles -> valid_o high 3 consecutive cycles starting 2 edges after the first, data in order.
REQ-034 N_ENTRIES=16; pulse rst at clear cycle 7 -> busy restarts, stays 1 for 16 full cycles, and en during busy causes no write and no valid_o.
